// File: rtl/frame_sequencer.sv
// Per-frame controller: clears FB/ZB, launches geometry, waits for the pipeline to drain, swaps on vsync.
// Optional FRAME_SEQ_AUTO_RUN_EN: the swap goes straight back into CLEAR for continuous rendering.
module frame_sequencer #(
    parameter int          FB_DEPTH     = 76800,
    parameter int          ADDR_W       = 17,
    parameter logic [11:0] CLEAR_COLOR  = 12'h000,
    parameter logic [7:0]  Z_FAR        = 8'hFF,
    parameter int          IDLE_CONFIRM = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_vsync,
    output logic              o_geo_start,
    input  logic              i_geo_done,
    input  logic              i_fifo_empty,
    input  logic              i_tri_valid,
    input  logic              i_raster_busy,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_fb_we,
    output logic [11:0]       o_clr_fb_pixel,
    output logic              o_clr_zb_we,
    output logic [7:0]        o_clr_zb_data,
    output logic              o_back_buf,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [15:0]       o_frame_count
);

    // The idle counter only has to reach IDLE_CONFIRM-1.
    localparam int                CNT_W     = (IDLE_CONFIRM > 1) ? $clog2(IDLE_CONFIRM) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_IDLE = CNT_W'(IDLE_CONFIRM - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_GEO        = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_WAIT_VSYNC = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              fb_we_r;
    logic              zb_we_r;
    logic [11:0]       pixel_r;
    logic [7:0]        zdata_r;
    logic              geo_start_r;
    logic              back_buf_r;
    logic              busy_r;
    logic              frame_done_r;
    logic [15:0]       frame_count_r;
    logic [CNT_W-1:0]  idle_cnt_r;
    logic              idle_s;

    // Pipeline is idle when nothing is queued, assembling or rasterizing.
    always_comb begin
        idle_s = 1'b0;
        if (i_fifo_empty && !i_tri_valid && !i_raster_busy) begin
            idle_s = 1'b1;
        end else begin
            idle_s = 1'b0;
        end
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            fb_we_r       <= 1'b0;
            zb_we_r       <= 1'b0;
            pixel_r       <= 12'h000;
            zdata_r       <= 8'h00;
            geo_start_r   <= 1'b0;
            back_buf_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
            idle_cnt_r    <= '0;
        end else begin
            geo_start_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_r <= ST_CLEAR;
                        addr_r  <= '0;
                        fb_we_r <= 1'b1;
                        zb_we_r <= 1'b1;
                        pixel_r <= CLEAR_COLOR;
                        zdata_r <= Z_FAR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (addr_r == LAST_ADDR) begin
                        state_r     <= ST_GEO;
                        addr_r      <= '0;
                        fb_we_r     <= 1'b0;
                        zb_we_r     <= 1'b0;
                        pixel_r     <= 12'h000;
                        zdata_r     <= 8'h00;
                        geo_start_r <= 1'b1;
                    end else begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end
                ST_GEO: begin
                    if (i_geo_done) begin
                        state_r    <= ST_DRAIN;
                        idle_cnt_r <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Any non-idle cycle restarts the confirmation window.
                    if (!idle_s) begin
                        idle_cnt_r <= '0;
                    end else if (idle_cnt_r == LAST_IDLE) begin
                        state_r    <= ST_WAIT_VSYNC;
                        idle_cnt_r <= '0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_VSYNC: begin
                    if (i_vsync) begin
                        back_buf_r    <= ~back_buf_r;
                        frame_done_r  <= 1'b1;
                        frame_count_r <= frame_count_r + 16'd1;
`ifdef FRAME_SEQ_AUTO_RUN_EN
                        state_r <= ST_CLEAR;
                        addr_r  <= '0;
                        fb_we_r <= 1'b1;
                        zb_we_r <= 1'b1;
                        pixel_r <= CLEAR_COLOR;
                        zdata_r <= Z_FAR;
                        busy_r  <= 1'b1;
`else
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    addr_r     <= '0;
                    fb_we_r    <= 1'b0;
                    zb_we_r    <= 1'b0;
                    pixel_r    <= 12'h000;
                    zdata_r    <= 8'h00;
                    busy_r     <= 1'b0;
                    idle_cnt_r <= '0;
                end
            endcase
        end
    end

    assign o_geo_start    = geo_start_r;
    assign o_clr_addr     = addr_r;
    assign o_clr_fb_we    = fb_we_r;
    assign o_clr_fb_pixel = pixel_r;
    assign o_clr_zb_we    = zb_we_r;
    assign o_clr_zb_data  = zdata_r;
    assign o_back_buf     = back_buf_r;
    assign o_busy         = busy_r;
    assign o_frame_done   = frame_done_r;
    assign o_frame_count  = frame_count_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: random drain/vsync patterns checked against a rule-level model.
module tb_frame_sequencer;

    localparam int          FB_DEPTH     = 16;
    localparam int          ADDR_W       = 4;
    localparam int          IDLE_CONFIRM = 4;
    localparam logic [11:0] CLR_C        = 12'h000;
    localparam logic [7:0]  ZF           = 8'hFF;
`ifdef FRAME_SEQ_AUTO_RUN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start, i_vsync, i_geo_done, i_fifo_empty, i_tri_valid, i_raster_busy;
    logic              o_geo_start, o_clr_fb_we, o_clr_zb_we, o_back_buf, o_busy, o_frame_done;
    logic [ADDR_W-1:0] o_clr_addr;
    logic [11:0]       o_clr_fb_pixel;
    logic [7:0]        o_clr_zb_data;
    logic [15:0]       o_frame_count;

    int          total = 0;
    int          bad   = 0;
    logic        m_back;
    logic [15:0] m_count;

    frame_sequencer #(
        .FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .CLEAR_COLOR(CLR_C), .Z_FAR(ZF), .IDLE_CONFIRM(IDLE_CONFIRM)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_vsync(i_vsync),
        .o_geo_start(o_geo_start), .i_geo_done(i_geo_done), .i_fifo_empty(i_fifo_empty),
        .i_tri_valid(i_tri_valid), .i_raster_busy(i_raster_busy), .o_clr_addr(o_clr_addr),
        .o_clr_fb_we(o_clr_fb_we), .o_clr_fb_pixel(o_clr_fb_pixel), .o_clr_zb_we(o_clr_zb_we),
        .o_clr_zb_data(o_clr_zb_data), .o_back_buf(o_back_buf), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_fb_we"}, 32'(o_clr_fb_we), 32'd0);
        chk({tag, "_zb_we"}, 32'(o_clr_zb_we), 32'd0);
        chk({tag, "_addr"}, 32'(o_clr_addr), 32'd0);
        chk({tag, "_pixel"}, 32'(o_clr_fb_pixel), 32'd0);
        chk({tag, "_zdata"}, 32'(o_clr_zb_data), 32'd0);
        chk({tag, "_geo"}, 32'(o_geo_start), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_frame_done), 32'd0);
        chk({tag, "_back"}, 32'(o_back_buf), 32'(m_back));
        chk({tag, "_count"}, 32'(o_frame_count), 32'(m_count));
    endtask

    // One frame: clear, geometry, drain pattern, swap. Clear is already visible when need_start=0.
    task automatic do_frame(input bit need_start, input bit directed);
        bit nonidle[64];
        int kind[64];
        bit vs[96];
        int x, w, g, run, len, last;
        for (int j = 0; j < 64; j++) begin
            nonidle[j] = 1'b0;
            kind[j]    = 0;
        end
        if (need_start) begin
            i_start = 1'b1;
            step();
            i_start = 1'b0;
        end
        for (int k = 0; k < FB_DEPTH; k++) begin
            chk("clr_addr", 32'(o_clr_addr), 32'(k));
            chk("clr_fb_we", 32'(o_clr_fb_we), 32'd1);
            chk("clr_zb_we", 32'(o_clr_zb_we), 32'd1);
            chk("clr_pixel", 32'(o_clr_fb_pixel), 32'(CLR_C));
            chk("clr_zdata", 32'(o_clr_zb_data), 32'(ZF));
            chk("clr_geo", 32'(o_geo_start), 32'd0);
            chk("clr_busy", 32'(o_busy), 32'd1);
            if (k < FB_DEPTH - 1) begin
                i_start = ($urandom_range(0, 3) == 0);
                step();
                i_start = 1'b0;
            end
        end
        step();
        chk("geo_start", 32'(o_geo_start), 32'd1);
        chk("geo_fb_we", 32'(o_clr_fb_we), 32'd0);
        chk("geo_zb_we", 32'(o_clr_zb_we), 32'd0);
        chk("geo_pixel", 32'(o_clr_fb_pixel), 32'd0);
        g = directed ? 0 : int'($urandom_range(0, 2));
        for (int i = 0; i < g; i++) begin
            i_vsync = $urandom_range(0, 1);
            step();
            i_vsync = 1'b0;
            chk("geo_hold", 32'(o_geo_start), 32'd0);
            chk("geo_noswap", 32'(o_frame_done), 32'd0);
        end
        i_geo_done = 1'b1;
        step();
        i_geo_done = 1'b0;
        chk("geo_pulse_end", 32'(o_geo_start), 32'd0);
        // Drain activity pattern, indexed from the first DRAIN cycle.
        if (directed) begin
            for (int j = 0; j < 5; j++) begin
                nonidle[j] = 1'b1;
                kind[j]    = 2;
            end
            nonidle[7] = 1'b1;
            kind[7]    = 1;
        end else begin
            len = $urandom_range(0, 12);
            for (int j = 0; j < len; j++) begin
                nonidle[j] = $urandom_range(0, 1);
                kind[j]    = $urandom_range(0, 2);
            end
        end
        run = 0;
        x   = 0;
        for (int j = 0; j < 64; j++) begin
            if (nonidle[j]) run = 0;
            else run++;
            if (run == IDLE_CONFIRM) begin
                x = j;
                break;
            end
        end
        w = directed ? 0 : int'($urandom_range(0, 4));
        for (int j = 0; j < 96; j++) vs[j] = 1'b0;
        for (int j = 0; j < x; j++) vs[j] = $urandom_range(0, 1);
        vs[x] = 1'b1;
        last = x + 1 + w;
        vs[last] = 1'b1;
        for (int j = 0; j <= last; j++) begin
            i_fifo_empty  = !(j < 64 && nonidle[j] && kind[j] == 0);
            i_tri_valid   = (j < 64 && nonidle[j] && kind[j] == 1);
            i_raster_busy = (j < 64 && nonidle[j] && kind[j] == 2);
            i_vsync       = vs[j];
            i_start       = (j == last);
            step();
            if (j == last) begin
                m_back  = ~m_back;
                m_count = m_count + 16'd1;
            end
            chk("done_timing", 32'(o_frame_done), 32'(j == last));
            chk("back_buf", 32'(o_back_buf), 32'(m_back));
            chk("frame_count", 32'(o_frame_count), 32'(m_count));
            chk("drain_busy", 32'(o_busy), (j == last) ? 32'(AUTO) : 32'd1);
        end
        i_fifo_empty  = 1'b1;
        i_tri_valid   = 1'b0;
        i_raster_busy = 1'b0;
        i_vsync       = 1'b0;
        i_start       = 1'b0;
        chk("swap_fb_we", 32'(o_clr_fb_we), 32'(AUTO));
        chk("swap_addr", 32'(o_clr_addr), 32'd0);
        if (!AUTO) begin
            step();
            chk_quiet("post_swap");
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0; i_vsync = 1'b0; i_geo_done = 1'b0;
        i_fifo_empty = 1'b1; i_tri_valid = 1'b0; i_raster_busy = 1'b0;
        m_back = 1'b0;
        m_count = 16'd0;
        repeat (3) step();
        chk_quiet("reset");
        rst = 1'b0;
        step();
        chk_quiet("after_reset");

        do_frame(1'b1, 1'b1);
        do_frame(!AUTO, 1'b0);
        do_frame(!AUTO, 1'b0);

        // Abort a clear at address 7.
        if (!AUTO) begin
            i_start = 1'b1;
            step();
            i_start = 1'b0;
        end
        repeat (7) step();
        chk("mid_clear_addr", 32'(o_clr_addr), 32'd7);
        chk("mid_clear_we", 32'(o_clr_fb_we), 32'd1);
        rst = 1'b1;
        #1;
        m_back  = 1'b0;
        m_count = 16'd0;
        chk_quiet("async_abort");
        step();
        step();
        chk_quiet("abort_hold");
        rst = 1'b0;
        step();
        chk_quiet("abort_release");

        do_frame(1'b1, 1'b0);
        do_frame(!AUTO, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame controller for the render pipeline. Clears the back framebuffer and the Z-buffer, launches the geometry engine, and waits for the vertex FIFO, triangle assembler and rasterizer to drain. It then swaps front/back buffers on the next vertical sync. It sits beside the geometry → vertex FIFO → assembler → rasterizer chain and owns the clear-write ports, which are muxed with the rasterizer's framebuffer and Z-buffer write ports downstream.

## Interface
Parameters:
- FB_DEPTH, 76800, number of pixel/Z locations (320×240)
- ADDR_W, 17, address width; must satisfy 2^ADDR_W ≥ FB_DEPTH
- CLEAR_COLOR, 12'h000, 12-bit pixel written during clear
- Z_FAR, 8'hFF, depth value written during clear
- IDLE_CONFIRM, 4, consecutive idle cycles required to declare the pipeline drained (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  pulse; begin a frame (sampled only in IDLE)
- i_vsync  in  1  pulse, already synchronous to i_clk; display frame boundary
- o_geo_start  out  1  one-cycle pulse to the geometry engine
- i_geo_done  in  1  pulse; geometry engine has emitted its last vertex
- i_fifo_empty  in  1  vertex FIFO empty
- i_tri_valid  in  1  assembler triangle valid
- i_raster_busy  in  1  rasterizer busy
- o_clr_addr  out  ADDR_W  clear write address (shared by FB and ZB)
- o_clr_fb_we  out  1  framebuffer clear write enable
- o_clr_fb_pixel  out  12  CLEAR_COLOR while o_clr_fb_we=1, else 0
- o_clr_zb_we  out  1  Z-buffer clear write enable
- o_clr_zb_data  out  8  Z_FAR while o_clr_zb_we=1, else 0
- o_back_buf  out  1  buffer index being rendered; display reads !o_back_buf
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse on buffer swap
- o_frame_count  out  16  completed frames, wraps at 16'hFFFF→0

## Operation
- Five states: IDLE, CLEAR, GEO, DRAIN, WAIT_VSYNC.
- **IDLE:** i_start=1 → CLEAR with address counter = 0.
- **CLEAR:** each cycle writes the current address to both FB and ZB, then increments the counter.
  - After writing FB_DEPTH-1 → GEO.
- **GEO:** o_geo_start is high on the first GEO cycle only.
  - i_geo_done sampled in GEO (including the first cycle) → DRAIN, idle counter = 0.
- **DRAIN:** idle = i_fifo_empty & !i_tri_valid & !i_raster_busy.
  - Idle counter increments while idle and resets to 0 on any non-idle cycle.
  - Idle with counter = IDLE_CONFIRM-1 → WAIT_VSYNC.
- **WAIT_VSYNC:** i_vsync=1 → toggle o_back_buf, pulse o_frame_done, increment o_frame_count, then go to the next state (see Configuration).
- Ignored inputs:
  - i_start outside IDLE.
  - i_geo_done outside GEO.
  - i_vsync outside WAIT_VSYNC.
- All outputs are registered. The address counter is ADDR_W bits and never exceeds FB_DEPTH-1.

## Timing
- **Reset:** all outputs = 0 (o_back_buf=0, o_frame_count=0); state = IDLE; counters = 0.
- Reset mid-operation aborts immediately (asynchronously): write enables drop with no partial-frame swap.
- **Clear phase:**
  - i_start sampled high in cycle T → first clear write (addr 0) visible in T+1.
  - Writes are on FB_DEPTH consecutive cycles with no gaps; FB and ZB enables are identical.
- **Geometry launch:** o_geo_start is high in cycle T+1+FB_DEPTH. Write enables are 0 in that cycle.
- **Drain detection:** the minimum DRAIN dwell is IDLE_CONFIRM cycles.
- **Swap:** i_vsync sampled in cycle V → o_back_buf toggled, o_frame_done=1 and o_frame_count updated in V+1.
- **Simultaneous events:**
  - i_vsync in the same cycle the DRAIN exit condition is met is not a swap; the sequencer waits for the next i_vsync.
  - i_start on the same cycle that WAIT_VSYNC → IDLE is ignored.

## Configuration
- FRAME_SEQ_AUTO_RUN_EN defined:
  - The swap transitions directly to CLEAR (continuous rendering).
  - The first clear write occurs in the same cycle as o_frame_done.
  - i_start is only needed for the first frame; o_busy stays 1.
- Undefined: the swap transitions to IDLE, and every frame requires i_start.

## Test plan
Bench uses FB_DEPTH=16, IDLE_CONFIRM=4.
- **Reset values:** assert i_rst for 3 cycles → all outputs 0, o_busy=0.
- **Clear sequence:** i_start pulse at T → o_clr_addr 0..15 at T+1..T+16, both enables 1 with pixel 12'h000 and Z 8'hFF; o_geo_start=1 only at T+17.
- **Drain with glitch:**
  - i_geo_done; i_raster_busy=1 for 5 cycles; then idle for 2 cycles; i_tri_valid=1 for 1 cycle; then idle.
  - → WAIT_VSYNC is reached exactly 4 idle cycles after the last non-idle cycle.
- **Swap:**
  - i_vsync in WAIT_VSYNC → next cycle o_back_buf=1, o_frame_done=1 for one cycle, o_frame_count=1.
  - A second frame → o_back_buf=0, o_frame_count=2.
- **Ignored inputs:** i_start during CLEAR, and i_vsync during GEO/DRAIN → no state change, no extra clear, no swap.
- **Reset mid-clear at addr 7:** enables 0 and o_clr_addr=0 during reset. After release, i_start restarts the clear from addr 0. With FRAME_SEQ_AUTO_RUN_EN, the post-swap clear starts without i_start.
